highway_ctrl: RTL and testbench

//  Highway-side traffic-light controller; peer of the country-road controller across the enable_c/enable_h handshake.

---
 rtl/traffic_pkg.sv | 37 +++
 rtl/highway_ctrl_phase_timer.sv | 38 +++
 rtl/highway_ctrl.sv | 108 ++++++++++
 tb/tb_highway_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the highway/country traffic-light controller pair.
// Contents:
//   LED_GREEN/LED_YELLOW/LED_RED - 3-bit one-hot light codes used by both controllers
//   hw_state_t                   - highway controller phase encoding
//   hw_led()                     - phase to light decode
//   max4()                       - largest of four timing parameters, used to size phase counters
package traffic_pkg;

    localparam logic [2:0] LED_GREEN  = 3'b001;
    localparam logic [2:0] LED_YELLOW = 3'b010;
    localparam logic [2:0] LED_RED    = 3'b100;

    typedef enum logic [1:0] {
        GREEN     = 2'd0,
        YELLOW    = 2'd1,
        RED_CLEAR = 2'd2,
        RED_WAIT  = 2'd3
    } hw_state_t;

    function automatic logic [2:0] hw_led(input hw_state_t s);
        case (s)
            GREEN:   return LED_GREEN;
            YELLOW:  return LED_YELLOW;
            default: return LED_RED;
        endcase
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/highway_ctrl_phase_timer.sv
// Saturating per-phase cycle counter, shared with the country-road controller.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset, clears the count
//   clear_i  - restart the count at zero on the next edge (phase entry)
//   en_i     - count one per cycle while high
//   cnt_o    - current count; holds at all-ones instead of wrapping
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/highway_ctrl.sv
// Highway-side traffic-light controller. Rests green; a latched country-road
// request (after minimum green) runs yellow, then an all-red guard, then hands
// right-of-way to the country controller with a one-cycle enable_c pulse and
// waits for the enable_h return pulse. A watchdog returns to green and sets a
// sticky fault if enable_h never arrives.
// Ports:
//   clk          - system clock, all logic on posedge
//   rst          - synchronous active-high reset
//   car_sensor   - country-road vehicle present (level)
//   enable_h     - one-cycle pulse from the country controller: highway may go
//   enable_c     - one-cycle pulse to the country controller: country may go
//   led_highway  - one-hot light (001 green, 010 yellow, 100 red)
//   fault        - sticky watchdog-expired flag
module highway_ctrl
    import traffic_pkg::*;
#(
    parameter int T_GREEN_MIN = 15,
    parameter int T_YELLOW    = 10,
    parameter int T_CLEAR     = 2,
    parameter int T_RED_MAX   = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_sensor,
    input  logic       enable_h,
    output logic       enable_c,
    output logic [2:0] led_highway,
    output logic       fault
);

    localparam int CNT_W = $clog2(max4(T_GREEN_MIN, T_YELLOW, T_CLEAR, T_RED_MAX)) + 1;

    // Last count value of each timed phase (phase of N cycles ends at count N-1).
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(T_CLEAR - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(T_RED_MAX - 1);

    hw_state_t        state_q, state_d;
    logic             req_q, req_d;
    logic             enable_c_q, enable_c_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt;
    logic             wd_expire;

    // Counter restarts whenever the phase changes; no phase transitions to itself.
    phase_timer #(.W(CNT_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_d != state_q),
        .en_i    (1'b1),
        .cnt_o   (cnt)
    );

    always_comb begin
        state_d   = state_q;
        wd_expire = 1'b0;
        case (state_q)
            GREEN: begin
                // Current-cycle car_sensor counts too, so a car arriving exactly at minimum green is not delayed.
                if ((cnt >= GREEN_LAST) && (req_q || car_sensor)) state_d = YELLOW;
            end
            YELLOW: begin
                if (cnt >= YELLOW_LAST) state_d = RED_CLEAR;
            end
            RED_CLEAR: begin
                if (cnt >= CLEAR_LAST) state_d = RED_WAIT;
            end
            RED_WAIT: begin
                // enable_h takes priority over a watchdog expiry in the same cycle.
                if (enable_h) begin
                    state_d = GREEN;
                end else if (cnt >= WAIT_LAST) begin
                    state_d   = GREEN;
                    wd_expire = 1'b1;
                end
            end
            default: state_d = GREEN;
        endcase

        // Request latches only in green and is dropped on the way into yellow.
        req_d = 1'b0;
        if ((state_q == GREEN) && (state_d == GREEN)) req_d = req_q || car_sensor;

        // Handover pulse coincides with the first RED_WAIT cycle.
        enable_c_d = (state_q == RED_CLEAR) && (state_d == RED_WAIT);
        fault_d    = fault_q || wd_expire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= GREEN;
            req_q      <= 1'b0;
            enable_c_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            enable_c_q <= enable_c_d;
            fault_q    <= fault_d;
        end
    end

    assign led_highway = hw_led(state_q);
    assign enable_c    = enable_c_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_highway_ctrl.sv
// Directed and randomized bench for highway_ctrl with short timing parameters.
// Cycle numbering: cycle 0 is the first cycle after the last reset edge.
module tb_highway_ctrl;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       car_sensor = 1'b0;
    logic       enable_h = 1'b0;
    logic       enable_c;
    logic [2:0] led_highway;
    logic       fault;

    int n_checks = 0;
    int n_fail   = 0;

    highway_ctrl #(
        .T_GREEN_MIN (4),
        .T_YELLOW    (2),
        .T_CLEAR     (1),
        .T_RED_MAX   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .car_sensor  (car_sensor),
        .enable_h    (enable_h),
        .enable_c    (enable_c),
        .led_highway (led_highway),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; outputs are then stable for the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        car_sensor = 1'b0;
        enable_h = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 50; c++) begin
            n_checks++;
            if (led_highway !== G) begin
                n_fail++;
                $display("FAIL idle_led cycle %0d: got %b expected %b", c, led_highway, G);
            end
            n_checks++;
            if (enable_c !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_enable_c cycle %0d: got %b expected 0", c, enable_c);
            end
            n_checks++;
            if (fault !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_fault cycle %0d: got %b expected 0", c, fault);
            end
            step();
        end
    endtask

    task automatic test_single_request();
        logic [2:0] exp_led;
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            exp_led = (c <= 3) ? G : (c <= 5) ? Y : (c <= 10) ? R : G;
            n_checks++;
            if (led_highway !== exp_led) begin
                n_fail++;
                $display("FAIL req_led cycle %0d: got %b expected %b", c, led_highway, exp_led);
            end
            n_checks++;
            if (enable_c !== (c == 7)) begin
                n_fail++;
                $display("FAIL req_enable_c cycle %0d: got %b expected %b", c, enable_c, (c == 7));
            end
            car_sensor = (c == 1);
            enable_h   = (c == 10);
            step();
        end
        car_sensor = 1'b0;
        enable_h   = 1'b0;
    endtask

    task automatic test_watchdog();
        logic [2:0] exp_led;
        logic       exp_ec;
        do_reset();
        for (int c = 0; c <= 26; c++) begin
            exp_led = (c <= 3)  ? G : (c <= 5)  ? Y : (c <= 14) ? R :
                      (c <= 18) ? G : (c <= 20) ? Y : (c <= 23) ? R : G;
            exp_ec  = (c == 7) || (c == 22);
            n_checks++;
            if (led_highway !== exp_led) begin
                n_fail++;
                $display("FAIL wd_led cycle %0d: got %b expected %b", c, led_highway, exp_led);
            end
            n_checks++;
            if (enable_c !== exp_ec) begin
                n_fail++;
                $display("FAIL wd_enable_c cycle %0d: got %b expected %b", c, enable_c, exp_ec);
            end
            n_checks++;
            if (fault !== (c >= 15)) begin
                n_fail++;
                $display("FAIL wd_fault cycle %0d: got %b expected %b", c, fault, (c >= 15));
            end
            car_sensor = (c <= 15);
            enable_h   = (c == 23);
            step();
        end
        car_sensor = 1'b0;
        enable_h   = 1'b0;
    endtask

    task automatic test_enable_h_ignored();
        logic [2:0] exp_led;
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            exp_led = (c <= 3) ? G : (c <= 5) ? Y : (c <= 14) ? R : G;
            n_checks++;
            if (led_highway !== exp_led) begin
                n_fail++;
                $display("FAIL ehign_led cycle %0d: got %b expected %b", c, led_highway, exp_led);
            end
            n_checks++;
            if (enable_c !== (c == 7)) begin
                n_fail++;
                $display("FAIL ehign_enable_c cycle %0d: got %b expected %b", c, enable_c, (c == 7));
            end
            n_checks++;
            if (fault !== 1'b0) begin
                n_fail++;
                $display("FAIL ehign_fault cycle %0d: got %b expected 0", c, fault);
            end
            car_sensor = (c == 0);
            // Pulses in green, yellow and red-clear, then one exactly on the watchdog's last cycle.
            enable_h   = (c == 1) || (c == 2) || (c == 4) || (c == 5) || (c == 6) || (c == 14);
            step();
        end
        car_sensor = 1'b0;
        enable_h   = 1'b0;
    endtask

    task automatic test_reset_mid_phase();
        logic [2:0] exp_led;
        // Reset during yellow.
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            exp_led = (c <= 3) ? G : Y;
            n_checks++;
            if (led_highway !== exp_led) begin
                n_fail++;
                $display("FAIL rsty_pre_led cycle %0d: got %b expected %b", c, led_highway, exp_led);
            end
            car_sensor = (c == 0);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int r = 0; r <= 5; r++) begin
            exp_led = (r <= 3) ? G : Y;
            n_checks++;
            if (led_highway !== exp_led) begin
                n_fail++;
                $display("FAIL rsty_post_led cycle %0d: got %b expected %b", r, led_highway, exp_led);
            end
            n_checks++;
            if (enable_c !== 1'b0) begin
                n_fail++;
                $display("FAIL rsty_enable_c cycle %0d: got %b expected 0", r, enable_c);
            end
            car_sensor = (r == 0);
            step();
        end
        // Reset during green with a request already latched: the request must not survive.
        do_reset();
        car_sensor = 1'b1;
        step();
        car_sensor = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int r = 0; r <= 7; r++) begin
            n_checks++;
            if (led_highway !== G) begin
                n_fail++;
                $display("FAIL rstg_led cycle %0d: got %b expected %b", r, led_highway, G);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic prev_ec = 1'b0;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            n_checks++;
            if (!$onehot(led_highway)) begin
                n_fail++;
                $display("FAIL rnd_onehot cycle %0d: got %b expected one-hot", c, led_highway);
            end
            n_checks++;
            if (enable_c && (led_highway !== R)) begin
                n_fail++;
                $display("FAIL rnd_ec_red cycle %0d: enable_c=1 with led %b expected %b", c, led_highway, R);
            end
            n_checks++;
            if (enable_c && prev_ec) begin
                n_fail++;
                $display("FAIL rnd_ec_b2b cycle %0d: got enable_c=1 twice expected single pulse", c);
            end
            prev_ec    = enable_c;
            car_sensor = ($urandom_range(0, 3) == 0);
            enable_h   = ($urandom_range(0, 7) == 0);
            step();
        end
        car_sensor = 1'b0;
        enable_h   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_watchdog();
        test_enable_h_ignored();
        test_reset_mid_phase();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
